// File: rtl/aes_key_expand_if.sv
// AES-128 key schedule bus: start/key request, round-key stream
// and random-read port into the round-key table.
interface aes_key_expand_if #(
  parameter int KEY_W = 128
);
  logic             start;
  logic [KEY_W-1:0] key_in;
  logic             busy;
  logic             done;
  logic             rk_valid;
  logic [3:0]       rk_round;
  logic [KEY_W-1:0] rk_out;
  logic [3:0]       rd_idx;
  logic [KEY_W-1:0] rd_key;

  modport master (
    output start, key_in, rd_idx,
    input  busy, done, rk_valid,
    input  rk_round, rk_out, rd_key
  );

  modport slave (
    input  start, key_in, rd_idx,
    output busy, done, rk_valid,
    output rk_round, rk_out, rd_key
  );
endinterface

// File: rtl/aes_key_expand.sv
// Sequential AES-128 key expansion: one round key per clock,
// streamed out and kept in a randomly readable table.
module aes_key_expand #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic            clk,
  input  logic            rst,
  aes_key_expand_if.slave bus
);

  typedef enum logic {IDLE, EXPAND} state_t;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  function automatic logic [7:0] xtime(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as x^254 (0 maps to 0), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  state_t           state;
  logic             busy;
  logic             done;
  logic             valid;
  logic [3:0]       round;
  logic [7:0]       rcon;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] nxt;
  logic [KEY_W-1:0] tbl [0:NUM_ROUNDS];

  logic [31:0] rot;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    rot = {key[23:0], key[31:24]};
    t   = {sbox(rot[31:24]) ^ rcon,
           sbox(rot[23:16]),
           sbox(rot[15:8]),
           sbox(rot[7:0])};
    n0  = key[127:96] ^ t;
    n1  = key[95:64]  ^ n0;
    n2  = key[63:32]  ^ n1;
    n3  = key[31:0]   ^ n2;
    nxt = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
      round <= '0;
      rcon  <= 8'h01;
      key   <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++)
        tbl[i] <= '0;
    end else begin
      // Table lags the stream by one edge: readers see the old entry
      // during the cycle the new round key is presented.
      if (valid) tbl[round] <= key;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state <= EXPAND;
            busy  <= 1'b1;
            valid <= 1'b1;
            round <= '0;
            rcon  <= 8'h01;
            key   <= bus.key_in;
          end
        end
        EXPAND: begin
          if (round == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
          end else begin
            key   <= nxt;
            round <= round + 4'd1;
            rcon  <= xtime(rcon);
            done  <= (round + 4'd1 == LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.rk_valid = valid;
  assign bus.rk_round = round;
  assign bus.rk_out   = key;
  assign bus.rd_key   = (bus.rd_idx <= LAST) ?
                        tbl[bus.rd_idx] : '0;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and zero-key
// schedules, back-to-back starts and mid-expansion reset.
module tb_aes_key_expand;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  aes_key_expand_if bus ();

  aes_key_expand dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] r1;
    logic [127:0] r10;
  } vec_t;

  vec_t         vecs [2];
  logic [127:0] a1 [11];
  logic [127:0] z1;
  logic [127:0] z10;
  int           dones;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(
    input string name,
    input logic  b,
    input logic  d,
    input logic  v
  );
    chk(name, {125'd0, bus.busy, bus.done, bus.rk_valid},
        {125'd0, b, d, v});
  endtask

  task automatic rd(
    input string        name,
    input logic [3:0]   idx,
    input logic [127:0] exp
  );
    bus.rd_idx = idx;
    #1;
    chk(name, bus.rd_key, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    z1     = 128'h62636363626363636263636362636363;
    z10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    vecs[0] = '{a1[0], a1[1], a1[10]};
    vecs[1] = '{128'd0, z1, z10};

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.key_in = '0;
    bus.rd_idx = '0;

    // Reset then idle
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk_ctl("idle_ctl", 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++)
      rd("reset_tbl", 4'(i), '0);

    // Table-driven single expansions
    for (int v = 0; v < 2; v++) begin
      bus.key_in = vecs[v].key;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      chk_ctl("r0_ctl", 1'b1, 1'b0, 1'b1);
      chk("r0_round", 128'(bus.rk_round), 128'd0);
      chk("r0_key", bus.rk_out, vecs[v].key);
      for (int r = 1; r <= 10; r++) begin
        step();
        chk_ctl("rr_ctl", 1'b1, r == 10, 1'b1);
        chk("rr_round", 128'(bus.rk_round), 128'(r));
        if (r == 1)  chk("r1_key", bus.rk_out, vecs[v].r1);
        if (r == 10) chk("r10_key", bus.rk_out, vecs[v].r10);
      end
      step();
      chk_ctl("end_ctl", 1'b0, 1'b0, 1'b0);
      chk("hold_key", bus.rk_out, vecs[v].r10);
      chk("hold_round", 128'(bus.rk_round), 128'd10);
      rd("tbl_r0", 4'd0, vecs[v].key);
      rd("tbl_r1", 4'd1, vecs[v].r1);
      rd("tbl_r10", 4'd10, vecs[v].r10);
      rd("tbl_r12", 4'd12, '0);
    end

    // Start held high, key changed mid-expansion
    bus.key_in = a1[0];
    bus.start  = 1'b1;
    dones = 0;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 13) begin
        rd("old_r5", 4'd5, a1[5]);
        rd("old_r0", 4'd0, a1[0]);
      end
      if (c == 14) rd("new_r0", 4'd0, '0);
      if (bus.done) dones++;
      if (c <= 11) begin
        chk_ctl("b2b_ctl1", 1'b1, c == 11, 1'b1);
        chk("b2b_key1", bus.rk_out, a1[c-1]);
      end else if (c == 12) begin
        chk_ctl("b2b_gap", 1'b0, 1'b0, 1'b0);
        chk("b2b_gap_key", bus.rk_out, a1[10]);
      end else if (c <= 23) begin
        chk_ctl("b2b_ctl2", 1'b1, c == 23, 1'b1);
        chk("b2b_round2", 128'(bus.rk_round), 128'(c - 13));
        if (c == 13) chk("b2b_z0", bus.rk_out, '0);
        if (c == 14) chk("b2b_z1", bus.rk_out, z1);
        if (c == 23) chk("b2b_z10", bus.rk_out, z10);
      end else begin
        chk_ctl("b2b_tail", 1'b0, 1'b0, 1'b0);
      end
      if (c == 3)  bus.key_in = '0;
      if (c == 23) bus.start = 1'b0;
    end
    chk("b2b_dones", 128'(dones), 128'd2);

    // Reset in the middle of an expansion
    bus.key_in = a1[0];
    bus.start  = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    chk("pre_rst_round", 128'(bus.rk_round), 128'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_ctl("rst_ctl", 1'b0, 1'b0, 1'b0);
    chk("rst_key", bus.rk_out, '0);
    chk("rst_round", 128'(bus.rk_round), 128'd0);
    for (int i = 0; i <= 10; i++)
      rd("rst_tbl", 4'(i), '0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.done) dones++;
    end
    chk("rst_no_done", 128'(dones), 128'd0);
    chk_ctl("rst_idle", 1'b0, 1'b0, 1'b0);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) step();
      chk_ctl("re_ctl", 1'b1, r == 10, 1'b1);
      chk("re_key", bus.rk_out, a1[r]);
    end
    step();
    chk_ctl("re_end", 1'b0, 1'b0, 1'b0);
    rd("re_tbl10", 4'd10, a1[10]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Sequential AES-128 key schedule (FIPS-197 KeyExpansion) that sits directly upstream of the AES round datapath. On a start request it latches a 128-bit cipher key and produces the 11 round keys, one per clock. Each round key is streamed out with a valid/round-index tag for the AddRoundKey stage. All round keys are also kept in an internal table that the round datapath can read randomly by index.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is legal; table depth is NUM_ROUNDS+1.
KEY_W, 128, key and round-key width in bits; fixed at 128.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  request expansion of key_in; sampled only in IDLE.
key_in  in  128  cipher key; key_in[127:96]=w0 … key_in[31:0]=w3; byte [127:120] maps to state[0][0] (column-major, same as cipher state).
busy  out  1  high while expansion is in progress.
done  out  1  one-cycle pulse when round key 10 is produced.
rk_valid  out  1  rk_out/rk_round are valid this cycle.
rk_round  out  4  index 0..10 of the round key on rk_out.
rk_out  out  128  streamed round key, same word/byte layout as key_in.
rd_idx  in  4  random-read index into the round-key table.
rd_key  out  128  table entry rd_idx (combinational read).

Behaviour:
- Reset: busy=0, done=0, rk_valid=0, rk_round=0, rk_out=0, all 11 table entries=0, FSM=IDLE, rcon=0x01. Reset takes priority over start in the same cycle.
- FSM states:
  - IDLE: start=1 at edge T latches key_in as round 0 and goes to EXPAND.
  - EXPAND: counter r=1..10, one round key per cycle.
  - After r=10 the FSM returns to IDLE. A separate DONE state is not used.
- Timing, relative to start sampled at edge T:
  - Cycle T+1: rk_valid=1, rk_round=0, rk_out=key_in, busy=1.
  - Cycle T+1+r: rk_round=r, rk_out=round key r, for r=1..10.
  - Cycle T+11: done=1 and busy=1, concurrent with round 10.
  - Cycle T+12: busy=0, done=0, rk_valid=0.
  - Latency from start to round 10 is 11 cycles.
- start while busy=1 is ignored; no queueing.
- start in the cycle immediately after done (busy already 0) is accepted; back-to-back expansions give rk_valid high for 11 of every 12 cycles.
- When rk_valid=0, rk_out and rk_round hold their last values.
- Round r computation, from previous key words p0..p3:
  - t = SubWord(RotWord(p3)) xor {rcon_r, 00, 00, 00}.
  - n0 = p0^t; n1 = p1^n0; n2 = p2^n1; n3 = p3^n2.
  - RotWord(a,b,c,d) = (b,c,d,a), with a as the MSB byte.
- Rcon sequence for r=1..10: 01,02,04,08,10,20,40,80,1B,36.
  - Generated by xtime (shift left; xor 0x1B if the MSB was set), not a lookup table.
  - rcon resets to 01 on each accepted start.
- SubWord uses four parallel FIPS-197 S-boxes, combinational within the cycle. The implementation choice (table or GF(2^8) inverse plus affine transform) is open, but the result must be bit-exact.
- Table:
  - Entry r is written in the same cycle rk_round=r is presented.
  - Entries persist until overwritten by the next expansion or cleared by rst.
  - During a new expansion, entries not yet rewritten still hold the previous key's values.
- rd_key: combinational from rd_idx. rd_idx 11..15 returns 0. Reading the entry being written this cycle returns the old value; the new value appears the next cycle.
- Reset mid-EXPAND: abort immediately, apply reset values, no done pulse; the next start begins from round 0.
- key_in changes after the start edge have no effect on the expansion in progress.

Test Plan:
- Reset then idle: assert rst 2 cycles, leave start low 20 cycles -> busy=0, done=0, rk_valid=0 throughout; rd_key=0 for every rd_idx 0..15.
- FIPS-197 A.1: key_in=2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle ->
  - T+1: round 0 = key_in.
  - T+2: round 1 = a0fafe1788542cb123a339392a6c7605.
  - T+11: round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with done=1 for exactly that cycle.
  - Then rd_idx=1 -> a0fafe17…7605; rd_idx=12 -> 0.
- Zero key: key_in=0 -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Busy/back-to-back:
  - Hold start high continuously with the A.1 key, and change key_in to 0 at T+3 -> every round still matches A.1.
  - The second expansion starts at T+12 (start re-sampled in IDLE), uses key_in=0 and produces the zero-key values.
  - Exactly one done pulse per expansion.
- Reset mid-operation: assert rst at T+5 for 1 cycle -> rk_valid, busy and done drop to 0 on the next cycle; no done pulse; table entries read 0. A new start with the A.1 key reproduces the A.1 values exactly, confirming rcon restarts at 01.
